hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Pipeline sequencing controller for the 5-stage SPARC-subset datapath (PC/nPC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives load enables for PC, nPC and IF/ID, and the control-signal mux select S that injects bubbles into ID/EX.
- Selects operand forwarding sources for the three ID register operands.
- Handles load-use stalls, the delayed-branch target select and the annul bit, post-reset pipeline flush, and a stall performance counter.

Parameters:
FLUSH_CYCLES, 2, cycles S is held at 1 after reset deasserts (number of pipeline stages to flush).
CNT_W, 16, width of the stall performance counter.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
R  in  1  synchronous reset, active-high.
ID_rs1, ID_rs2, ID_rd  in  5 each  register fields of the instruction in ID.
ID_use_rs1, ID_use_rs2, ID_use_rd  in  1 each  instruction in ID reads that field (ID_use_rd is set for stores).
EX_rd, MEM_rd, WB_rd  in  5 each  destination register held in each stage.
EX_RF_enable, MEM_RF_enable, WB_RF_enable  in  1 each  that stage will write the register file.
EX_load_instr  in  1  instruction in EX is a load.
EX_B_instr  in  1  instruction in EX is a conditional or unconditional branch.
EX_cond_true  in  1  branch condition evaluated true (valid when EX_B_instr=1).
EX_29_a  in  1  annul bit of the branch in EX.
PC_LE, nPC_LE, IF_ID_LE  out  1 each  register load enables.
S  out  1  1 selects all-zero control (bubble) into ID/EX; 0 passes control-unit output.
TA_sel  out  1  1 loads the branch target into nPC; 0 loads nPC+4.
fwd_a, fwd_b, fwd_d  out  2 each  operand source: 00 RF, 01 EX, 10 MEM, 11 WB.
stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
FSM states: FLUSH, RUN, STALL. Reset value is FLUSH with counter = 0 and stall_count = 0.

FLUSH state:
- S=1; PC_LE = nPC_LE = IF_ID_LE = 1; TA_sel=0.
- Counter increments each cycle. Exit to RUN after exactly FLUSH_CYCLES cycles with R=0.

Forwarding (combinational, every state):
- For each operand x in {rs1, rs2, rd}: if use_x and x != 0, choose the first matching stage in priority order EX, MEM, WB, where a stage matches if its RF_enable=1 and its rd equals x. Otherwise select 00.
- Register 0 is never forwarded.

Load-use hazard (combinational): hz = EX_load_instr & EX_RF_enable & EX_rd != 0 & (any used ID field == EX_rd).

RUN state:
- If hz: PC_LE = nPC_LE = IF_ID_LE = 0, S=1. Next state STALL. stall_count increments, saturating at all-ones.
- Otherwise: all LE = 1, S=0. Next state RUN.

STALL state:
- Lasts exactly one cycle; the load is now in MEM and forwarding selects 10.
- All LE = 1, S=0. Next state RUN.
- hz is ignored in STALL, so there is no double stall.

Branch handling (RUN or STALL, when EX_B_instr=1):
- taken = EX_cond_true. Then TA_sel=1 for that cycle; nPC loads the target and the delay slot (in ID) proceeds.
- Annul: if EX_29_a=1 and (not taken, or unconditional branch-always), S=1 that cycle to null the delay slot. The annul does not stall; all LE stay 1.
- Branch-always arrives as EX_cond_true=1 with an always-condition flag folded in by the condition unit. This block treats a=1 together with taken as annul only for branch-always, indicated by an additional internal decode of EX_cond_true with cond=1000 supplied on EX_29_a qualifying: the condition unit presents EX_29_a already qualified (1 means annul the slot).

Exclusivity and reset:
- hz and EX_B_instr cannot both be 1, because EX holds one instruction. If both are seen, hz takes precedence.
- R=1 in any state returns to FLUSH next cycle, clears the counter and stall_count, and drives the FLUSH outputs during reset.

Decomposition:
- Shared package: FSM state encoding, forwarding-select constants (FWD_RF/EX/MEM/WB), and the register-zero constant.
- One sub-module, fwd_select: a single-operand priority comparator, instantiated three times.

Test Plan:
1. Reset: R=1 for 2 cycles, then 0 -> S=1 for exactly 2 cycles, all LE=1, stall_count=0, then S=0.
2. EX: load r5 (RF_enable=1); ID: add with rs1=5 -> one cycle of LEs=0 and S=1. Next cycle fwd_a=10, LEs=1. stall_count=1.
3. EX writes r3, MEM writes r3, ID rs2=3 -> fwd_b=01. Remove the EX write -> fwd_b=10. With only WB writing -> fwd_b=11.
4. ID rs1=0 with EX_rd=0 and RF_enable=1 -> fwd_a=00 and no stall even if EX is a load.
5. EX_B_instr=1, cond_true=1, a=0 -> TA_sel=1, S=0. With cond_true=0 and a=1 -> TA_sel=0, S=1, LEs=1.
6. Assert R during STALL -> next cycle in FLUSH, stall_count=0; 256 back-to-back stalls with CNT_W=8 -> count saturates at 255.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// FSM encoding, forwarding-select codes and the hard-wired zero register.
package hazard_forward_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an ID operand field is actually read and names the given register.
  function automatic logic field_hits(input logic use_f, input logic [4:0] field,
                                      input logic [4:0] rd);
    return use_f && (field == rd);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Single-operand forwarding priority comparator: youngest writer (EX) wins,
// then MEM, then WB; register 0 always reads from the register file.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic       use_op,
  input  logic [4:0] op,
  input  logic [4:0] ex_rd,
  input  logic       ex_en,
  input  logic [4:0] mem_rd,
  input  logic       mem_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_en,
  output logic [1:0] sel
);

  logic [1:0] sel_s;

  // Priority match across the three writing stages.
  always_comb begin
    sel_s = FWD_RF;
    if (!use_op || (op == REG_ZERO)) begin
      sel_s = FWD_RF;
    end else if (ex_en && (ex_rd == op)) begin
      sel_s = FWD_EX;
    end else if (mem_en && (mem_rd == op)) begin
      sel_s = FWD_MEM;
    end else if (wb_en && (wb_rd == op)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  assign sel = sel_s;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline sequencing controller: load-use stall, delayed-branch target/annul,
// post-reset flush, operand forwarding selects and a saturating stall counter.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_use_rd,
  input  logic [4:0]       EX_rd,
  input  logic [4:0]       MEM_rd,
  input  logic [4:0]       WB_rd,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_load_instr,
  input  logic             EX_B_instr,
  input  logic             EX_cond_true,
  input  logic             EX_29_a,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             S,
  output logic             TA_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0]   stall_count_r;
  logic               hz_s;
  logic               le_s;
  logic               s_s;
  logic               ta_sel_s;
  logic               stall_inc_s;

  fwd_select u_fwd_a (
    .use_op (ID_use_rs1), .op (ID_rs1),
    .ex_rd  (EX_rd),  .ex_en  (EX_RF_enable),
    .mem_rd (MEM_rd), .mem_en (MEM_RF_enable),
    .wb_rd  (WB_rd),  .wb_en  (WB_RF_enable),
    .sel    (fwd_a)
  );

  fwd_select u_fwd_b (
    .use_op (ID_use_rs2), .op (ID_rs2),
    .ex_rd  (EX_rd),  .ex_en  (EX_RF_enable),
    .mem_rd (MEM_rd), .mem_en (MEM_RF_enable),
    .wb_rd  (WB_rd),  .wb_en  (WB_RF_enable),
    .sel    (fwd_b)
  );

  fwd_select u_fwd_d (
    .use_op (ID_use_rd), .op (ID_rd),
    .ex_rd  (EX_rd),  .ex_en  (EX_RF_enable),
    .mem_rd (MEM_rd), .mem_en (MEM_RF_enable),
    .wb_rd  (WB_rd),  .wb_en  (WB_RF_enable),
    .sel    (fwd_d)
  );

  assign hz_s = EX_load_instr && EX_RF_enable && (EX_rd != REG_ZERO) &&
                (field_hits(ID_use_rs1, ID_rs1, EX_rd) ||
                 field_hits(ID_use_rs2, ID_rs2, EX_rd) ||
                 field_hits(ID_use_rd,  ID_rd,  EX_rd));

  // Next state and sequencing outputs; reset overrides everything with the flush outputs.
  always_comb begin
    state_nxt_s = state_r;
    le_s        = 1'b1;
    s_s         = 1'b0;
    ta_sel_s    = 1'b0;
    stall_inc_s = 1'b0;
    if (R) begin
      s_s         = 1'b1;
      state_nxt_s = ST_FLUSH;
    end else begin
      case (state_r)
        ST_FLUSH: begin
          s_s = 1'b1;
          if (flush_cnt_r == FLUSH_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        ST_RUN: begin
          // A load-use hazard wins over a branch: EX cannot really hold both.
          if (hz_s) begin
            le_s        = 1'b0;
            s_s         = 1'b1;
            stall_inc_s = 1'b1;
            state_nxt_s = ST_STALL;
          end else if (EX_B_instr) begin
            ta_sel_s    = EX_cond_true;
            s_s         = EX_29_a;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: begin
          state_nxt_s = ST_RUN;
          if (EX_B_instr) begin
            ta_sel_s = EX_cond_true;
            s_s      = EX_29_a;
          end else begin
            ta_sel_s = 1'b0;
          end
        end
        default: begin
          s_s         = 1'b1;
          state_nxt_s = ST_FLUSH;
        end
      endcase
    end
  end

  // State, flush counter and saturating stall counter.
  always_ff @(posedge Clk) begin
    if (R) begin
      state_r       <= ST_FLUSH;
      flush_cnt_r   <= '0;
      stall_count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_FLUSH) && (state_nxt_s == ST_FLUSH)) begin
        flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
      end else begin
        flush_cnt_r <= '0;
      end
      if (stall_inc_s && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign PC_LE       = le_s;
  assign nPC_LE      = le_s;
  assign IF_ID_LE    = le_s;
  assign S           = s_s;
  assign TA_sel      = ta_sel_s;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: table of combinational vectors
// plus hand-written stall / reset / saturation sequences through a scoreboard.
module tb_hazard_forward_ctrl;

  localparam int CW = 8;

  typedef struct packed {
    logic       r;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ud;
    logic [4:0] exrd, memrd, wbrd;
    logic       exen, memen, wben;
    logic       ld, br, ct, a;
  } in_t;

  typedef struct packed {
    logic       le, s, ta;
    logic [1:0] fa, fb, fd;
  } oexp_t;

  typedef struct packed {
    oexp_t         o;
    logic [CW-1:0] cnt;
  } exp_t;

  logic Clk = 1'b0;
  logic R;
  logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_rd, MEM_rd, WB_rd;
  logic ID_use_rs1, ID_use_rs2, ID_use_rd;
  logic EX_RF_enable, MEM_RF_enable, WB_RF_enable;
  logic EX_load_instr, EX_B_instr, EX_cond_true, EX_29_a;
  logic PC_LE, nPC_LE, IF_ID_LE, S, TA_sel;
  logic [1:0] fwd_a, fwd_b, fwd_d;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  exp_t  exp_q[$];
  string name_q[$];

  hazard_forward_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .Clk(Clk), .R(R),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_use_rd(ID_use_rd),
    .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
    .EX_load_instr(EX_load_instr), .EX_B_instr(EX_B_instr),
    .EX_cond_true(EX_cond_true), .EX_29_a(EX_29_a),
    .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE), .S(S), .TA_sel(TA_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  function automatic oexp_t oe(input logic le, input logic s, input logic ta,
                               input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fd);
    oexp_t o;
    o.le = le; o.s = s; o.ta = ta; o.fa = fa; o.fb = fb; o.fd = fd;
    return o;
  endfunction

  task automatic drive(input in_t i);
    R = i.r;
    ID_rs1 = i.rs1; ID_rs2 = i.rs2; ID_rd = i.rd;
    ID_use_rs1 = i.u1; ID_use_rs2 = i.u2; ID_use_rd = i.ud;
    EX_rd = i.exrd; MEM_rd = i.memrd; WB_rd = i.wbrd;
    EX_RF_enable = i.exen; MEM_RF_enable = i.memen; WB_RF_enable = i.wben;
    EX_load_instr = i.ld; EX_B_instr = i.br; EX_cond_true = i.ct; EX_29_a = i.a;
  endtask

  task automatic check_one();
    exp_t e;
    string nm;
    logic [18:0] act, req;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    act = {PC_LE, nPC_LE, IF_ID_LE, S, TA_sel, fwd_a, fwd_b, fwd_d, stall_count};
    req = {e.o.le, e.o.le, e.o.le, e.o.s, e.o.ta, e.o.fa, e.o.fb, e.o.fd, e.cnt};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got {PC,nPC,IFID,S,TA,fa,fb,fd,cnt}=%b expected %b", nm, act, req);
    end
  endtask

  // One cycle: advance past the edge, drive, queue the expectation, compare at negedge.
  task automatic step(input in_t i, input oexp_t o, input string nm);
    @(posedge Clk);
    #1;
    drive(i);
    exp_q.push_back({o, exp_cnt});
    name_q.push_back(nm);
    @(negedge Clk);
    check_one();
  endtask

  task automatic bump_cnt();
    if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 8'd1;
  endtask

  in_t   tbl_in[14];
  oexp_t tbl_out[14];
  in_t   nz;
  in_t   rst_in;
  in_t   hz_in;

  initial begin
    nz     = in_t'(0);
    rst_in = nz; rst_in.r = 1'b1;
    drive(rst_in);

    tbl_in[0]  = nz;                                             tbl_out[0]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[1]  = nz; tbl_in[1].rs2 = 5'd3; tbl_in[1].u2 = 1'b1;
    tbl_in[1].exrd = 5'd3; tbl_in[1].exen = 1'b1; tbl_in[1].memrd = 5'd3; tbl_in[1].memen = 1'b1;
                                                                 tbl_out[1]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
    tbl_in[2]  = tbl_in[1]; tbl_in[2].exen = 1'b0;               tbl_out[2]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
    tbl_in[3]  = tbl_in[2]; tbl_in[3].memen = 1'b0;
    tbl_in[3].wbrd = 5'd3; tbl_in[3].wben = 1'b1;                tbl_out[3]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    tbl_in[4]  = tbl_in[3]; tbl_in[4].wben = 1'b0;               tbl_out[4]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[5]  = tbl_in[1]; tbl_in[5].u2 = 1'b0;                 tbl_out[5]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[6]  = nz; tbl_in[6].u1 = 1'b1; tbl_in[6].exen = 1'b1; tbl_in[6].ld = 1'b1;
                                                                 tbl_out[6]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[7]  = nz; tbl_in[7].rd = 5'd7; tbl_in[7].ud = 1'b1; tbl_in[7].memrd = 5'd7;
    tbl_in[7].memen = 1'b1; tbl_in[7].wbrd = 5'd7; tbl_in[7].wben = 1'b1;
                                                                 tbl_out[7]  = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
    tbl_in[8]  = nz; tbl_in[8].rs1 = 5'd4; tbl_in[8].rs2 = 5'd4; tbl_in[8].u1 = 1'b1;
    tbl_in[8].u2 = 1'b1; tbl_in[8].exrd = 5'd4; tbl_in[8].exen = 1'b1;
                                                                 tbl_out[8]  = oe(1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
    tbl_in[9]  = nz; tbl_in[9].br = 1'b1; tbl_in[9].ct = 1'b1;   tbl_out[9]  = oe(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    tbl_in[10] = nz; tbl_in[10].br = 1'b1; tbl_in[10].a = 1'b1;  tbl_out[10] = oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[11] = tbl_in[10]; tbl_in[11].ct = 1'b1;               tbl_out[11] = oe(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
    tbl_in[12] = nz; tbl_in[12].rs1 = 5'd6; tbl_in[12].u1 = 1'b1; tbl_in[12].exrd = 5'd6;
    tbl_in[12].ld = 1'b1;                                        tbl_out[12] = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    tbl_in[13] = nz; tbl_in[13].ct = 1'b1; tbl_in[13].a = 1'b1;  tbl_out[13] = oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

    // Reset held two cycles, then exactly two flush cycles before RUN.
    step(rst_in, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "reset_0");
    step(rst_in, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "reset_1");
    step(nz, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "flush_0");
    step(nz, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "flush_1");
    step(nz, oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00), "run_after_flush");

    // Load-use on rs1: one stall, then the load is forwarded from MEM.
    hz_in = nz; hz_in.rs1 = 5'd5; hz_in.u1 = 1'b1; hz_in.exrd = 5'd5; hz_in.exen = 1'b1; hz_in.ld = 1'b1;
    step(hz_in, oe(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00), "lu_rs1_stall");
    bump_cnt();
    begin
      in_t t;
      t = nz; t.rs1 = 5'd5; t.u1 = 1'b1; t.memrd = 5'd5; t.memen = 1'b1;
      step(t, oe(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00), "lu_rs1_after");
    end

    for (int k = 0; k < 14; k++)
      step(tbl_in[k], tbl_out[k], $sformatf("vec%0d", k));

    // Load-use through the store data field; STALL ignores the still-present hazard.
    hz_in = nz; hz_in.rd = 5'd8; hz_in.ud = 1'b1; hz_in.exrd = 5'd8; hz_in.exen = 1'b1; hz_in.ld = 1'b1;
    step(hz_in, oe(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01), "lu_rd_stall");
    bump_cnt();
    step(hz_in, oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01), "no_double_stall");

    // Hazard has precedence over a simultaneous branch; branch in STALL still selects target.
    hz_in = nz; hz_in.rs2 = 5'd9; hz_in.u2 = 1'b1; hz_in.exrd = 5'd9; hz_in.exen = 1'b1;
    hz_in.ld = 1'b1; hz_in.br = 1'b1; hz_in.ct = 1'b1; hz_in.a = 1'b1;
    step(hz_in, oe(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00), "hz_over_branch");
    bump_cnt();
    begin
      in_t t;
      t = nz; t.br = 1'b1; t.ct = 1'b1;
      step(t, oe(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00), "branch_in_stall");
    end

    // Reset during STALL: flush outputs at once, counter clears on the edge.
    hz_in = nz; hz_in.rs1 = 5'd5; hz_in.u1 = 1'b1; hz_in.exrd = 5'd5; hz_in.exen = 1'b1; hz_in.ld = 1'b1;
    step(hz_in, oe(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00), "pre_reset_stall");
    bump_cnt();
    step(rst_in, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "reset_in_stall");
    exp_cnt = '0;
    step(nz, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "reflush_0");
    step(nz, oe(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00), "reflush_1");
    step(nz, oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00), "rerun");

    // Back-to-back stalls: 260 of them, counter must stop at 255.
    for (int k = 0; k < 520; k++) begin
      if ((k % 2) == 0) begin
        step(hz_in, oe(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00), "sat_stall");
        bump_cnt();
      end else begin
        step(hz_in, oe(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00), "sat_release");
      end
    end
    step(nz, oe(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00), "sat_final");
    checks++;
    if (exp_cnt !== 8'd255 || stall_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_value: got %0d expected 255", stall_count);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
